// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared definitions for the ULPI register-access sequencer.
//   - PHY register addresses used by the configuration table
//   - configuration table ({addr, data} entries, written in index order)
//   - sequencer state encoding
package ulpi_pkg;

  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] IFC_CTRL  = 6'h07;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int unsigned CFG_LEN = 3;

  // Function Control 0x45: FS transceiver, TermSelect=1, OpMode normal, SuspendM=1
  localparam cfg_entry_t [0:CFG_LEN-1] CFG_TABLE = '{
    '{OTG_CTRL,  8'h00},
    '{FUNC_CTRL, 8'h45},
    '{IFC_CTRL,  8'h00}
  };

  typedef enum logic [3:0] {
    S_WAIT_READY,
    S_CFG_ISSUE,
    S_CFG_WAIT,
    S_CFG_VRFY_ISSUE,
    S_CFG_VRFY_WAIT,
    S_CFG_NEXT,
    S_RUN,
    S_HOST_ISSUE,
    S_HOST_WAIT
  } seq_state_t;

endpackage

// File: rtl/ulpi_reg_txn.sv
// ulpi_reg_txn: single register-transaction engine for the ULPI link port.
//   start/rw/addr/wdata/check : launch one transaction (one-cycle start)
//   abort                     : drop the transaction in flight
//   REG_DONE/REG_FAIL/REG_DATA_O : link completion inputs
//   reg_en/reg_rw/reg_addr/reg_data_i : registered link request outputs
//   ok/err                    : combinational outcome, valid only while pending
// A read launched with check=1 is compared against wdata; a mismatch is an err.
module ulpi_reg_txn #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       start,
  input  logic       abort,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  input  logic       check,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic [7:0] REG_DATA_O,
  output logic       reg_en,
  output logic       reg_rw,
  output logic [5:0] reg_addr,
  output logic [7:0] reg_data_i,
  output logic       ok,
  output logic       err
);

  // Timer is 0 in the strobe cycle, so the last waiting cycle is TIMEOUT-1;
  // the next strobe then lands TIMEOUT+1 cycles after the previous one.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        pending;
  logic        check_q;
  logic [15:0] timer;
  logic        done_ev;
  logic        fail_ev;
  logic        tmo_ev;
  logic        mismatch;

  // FAIL beats DONE; DONE beats timeout.
  always_comb begin
    fail_ev  = pending & REG_FAIL;
    done_ev  = pending & REG_DONE & ~REG_FAIL;
    tmo_ev   = pending & ~REG_DONE & ~REG_FAIL & (timer == TIMER_LAST);
    mismatch = check_q & (REG_DATA_O != reg_data_i);
    ok       = done_ev & ~mismatch;
    err      = fail_ev | tmo_ev | (done_ev & mismatch);
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      reg_en     <= 1'b0;
      reg_rw     <= 1'b0;
      reg_addr   <= '0;
      reg_data_i <= '0;
      pending    <= 1'b0;
      check_q    <= 1'b0;
      timer      <= '0;
    end else begin
      reg_en <= start;
      if (start) begin
        reg_rw     <= rw;
        reg_addr   <= addr;
        reg_data_i <= wdata;
        check_q    <= check & ~rw;
        pending    <= 1'b1;
        timer      <= '0;
      end else if (abort || ok || err) begin
        pending <= 1'b0;
      end else if (pending) begin
        timer <= timer + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_seq.sv
// ulpi_reg_seq: ULPI register-access sequencer.
// Writes and read-back-verifies the PHY configuration table whenever the link
// becomes READY, then serves host register requests. Sole driver of REG_*.
//   READY, REG_DONE, REG_FAIL, REG_DATA_O : link status / read data
//   REG_EN, REG_RW, REG_ADDR, REG_DATA_I   : link request (registered)
//   HOST_REQ/RW/ADDR/WDATA : host request (level, held until HOST_ACK)
//   HOST_ACK/RDATA/ERR     : host completion (one-cycle pulse)
//   CFG_DONE, CFG_ERR      : table finished / some entry failed (sticky)
module ulpi_reg_seq
  import ulpi_pkg::*;
#(
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned VERIFY         = 1
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       READY,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic [7:0] REG_DATA_O,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  input  logic       HOST_REQ,
  input  logic       HOST_RW,
  input  logic [5:0] HOST_ADDR,
  input  logic [7:0] HOST_WDATA,
  output logic       HOST_ACK,
  output logic [7:0] HOST_RDATA,
  output logic       HOST_ERR,
  output logic       CFG_DONE,
  output logic       CFG_ERR
);

  localparam logic [2:0] MAX_R    = 3'(MAX_RETRY);
  localparam logic [1:0] CFG_LAST = 2'(CFG_LEN - 1);

  seq_state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [2:0] retry, retry_n;
  logic       h_rw, h_rw_n;
  logic [5:0] h_addr, h_addr_n;
  logic [7:0] h_wdata, h_wdata_n;
  logic       ready_q;
  logic       ack_n, herr_n, cfg_done_n, cfg_err_n;
  logic [7:0] hrdata_n;

  logic       ready_fall;
  logic       t_start, t_rw, t_check, t_ok, t_err;
  logic [5:0] t_addr;
  logic [7:0] t_wdata;
  cfg_entry_t entry;

  ulpi_reg_txn #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_txn (
    .CLK_60M    (CLK_60M),
    .NRST_A_USB (NRST_A_USB),
    .start      (t_start),
    .abort      (ready_fall),
    .rw         (t_rw),
    .addr       (t_addr),
    .wdata      (t_wdata),
    .check      (t_check),
    .REG_DONE   (REG_DONE),
    .REG_FAIL   (REG_FAIL),
    .REG_DATA_O (REG_DATA_O),
    .reg_en     (REG_EN),
    .reg_rw     (REG_RW),
    .reg_addr   (REG_ADDR),
    .reg_data_i (REG_DATA_I),
    .ok         (t_ok),
    .err        (t_err)
  );

  always_comb begin
    entry      = CFG_TABLE[idx];
    ready_fall = ready_q & ~READY;
    state_n    = state;
    idx_n      = idx;
    retry_n    = retry;
    h_rw_n     = h_rw;
    h_addr_n   = h_addr;
    h_wdata_n  = h_wdata;
    ack_n      = 1'b0;
    herr_n     = 1'b0;
    hrdata_n   = HOST_RDATA;
    cfg_done_n = CFG_DONE;
    cfg_err_n  = CFG_ERR;
    t_start    = 1'b0;
    t_rw       = 1'b0;
    t_check    = 1'b0;
    t_addr     = entry.addr;
    t_wdata    = entry.data;

    if (state != S_WAIT_READY && ready_fall) begin
      state_n    = S_WAIT_READY;
      cfg_done_n = 1'b0;
      if (state == S_HOST_ISSUE || state == S_HOST_WAIT) begin
        ack_n    = 1'b1;
        herr_n   = 1'b1;
        hrdata_n = '0;
      end
    end else begin
      unique case (state)
        S_WAIT_READY: if (READY) begin
          state_n = S_CFG_ISSUE;
          idx_n   = '0;
          retry_n = '0;
        end
        S_CFG_ISSUE: if (READY) begin
          t_start = 1'b1;
          t_rw    = 1'b1;
          state_n = S_CFG_WAIT;
        end
        S_CFG_WAIT, S_CFG_VRFY_WAIT: begin
          if (t_ok) begin
            state_n = (state == S_CFG_WAIT && VERIFY != 0) ? S_CFG_VRFY_ISSUE : S_CFG_NEXT;
          end else if (t_err) begin
            // A failed readback reissues the write, not just the read.
            if (retry < MAX_R) begin
              retry_n = retry + 3'd1;
              state_n = S_CFG_ISSUE;
            end else begin
              cfg_err_n = 1'b1;
              state_n   = S_CFG_NEXT;
            end
          end
        end
        S_CFG_VRFY_ISSUE: if (READY) begin
          t_start = 1'b1;
          t_check = 1'b1;
          state_n = S_CFG_VRFY_WAIT;
        end
        S_CFG_NEXT: begin
          if (idx == CFG_LAST) begin
            state_n    = S_RUN;
            cfg_done_n = 1'b1;
          end else begin
            idx_n   = idx + 2'd1;
            retry_n = '0;
            state_n = S_CFG_ISSUE;
          end
        end
        // Ignore the request during the ACK cycle: the host drops it one cycle later.
        S_RUN: if (READY && HOST_REQ && !HOST_ACK) begin
          h_rw_n    = HOST_RW;
          h_addr_n  = HOST_ADDR;
          h_wdata_n = HOST_WDATA;
          retry_n   = '0;
          state_n   = S_HOST_ISSUE;
        end
        S_HOST_ISSUE: if (READY) begin
          t_start = 1'b1;
          t_rw    = h_rw;
          t_addr  = h_addr;
          t_wdata = h_wdata;
          state_n = S_HOST_WAIT;
        end
        S_HOST_WAIT: begin
          if (t_ok) begin
            ack_n    = 1'b1;
            hrdata_n = h_rw ? 8'h00 : REG_DATA_O;
            state_n  = S_RUN;
          end else if (t_err) begin
            if (retry < MAX_R) begin
              retry_n = retry + 3'd1;
              state_n = S_HOST_ISSUE;
            end else begin
              ack_n    = 1'b1;
              herr_n   = 1'b1;
              hrdata_n = '0;
              state_n  = S_RUN;
            end
          end
        end
        default: state_n = S_WAIT_READY;
      endcase
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state      <= S_WAIT_READY;
      idx        <= '0;
      retry      <= '0;
      h_rw       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      ready_q    <= 1'b0;
      HOST_ACK   <= 1'b0;
      HOST_ERR   <= 1'b0;
      HOST_RDATA <= '0;
      CFG_DONE   <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      retry      <= retry_n;
      h_rw       <= h_rw_n;
      h_addr     <= h_addr_n;
      h_wdata    <= h_wdata_n;
      ready_q    <= READY;
      HOST_ACK   <= ack_n;
      HOST_ERR   <= herr_n;
      HOST_RDATA <= hrdata_n;
      CFG_DONE   <= cfg_done_n;
      CFG_ERR    <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_seq.sv
// tb_ulpi_reg_seq: bench for ulpi_reg_seq with a behavioural link model, a
// transaction-level reference model feeding expected strobes/host responses
// into queues, and a monitor that pops and compares on REG_EN / HOST_ACK.
module tb_ulpi_reg_seq;

  localparam int unsigned MAXR   = 3;
  localparam int unsigned TMO    = 20;
  localparam int unsigned LAT    = 5;
  localparam int unsigned BUDGET = 3000;

  logic       CLK_60M = 1'b0;
  logic       NRST_A_USB = 1'b1;
  logic       READY = 1'b0;
  logic       REG_DONE = 1'b0;
  logic       REG_FAIL = 1'b0;
  logic [7:0] REG_DATA_O = 8'h00;
  logic       REG_EN, REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I;
  logic       HOST_REQ = 1'b0;
  logic       HOST_RW = 1'b0;
  logic [5:0] HOST_ADDR = 6'h00;
  logic [7:0] HOST_WDATA = 8'h00;
  logic       HOST_ACK, HOST_ERR, CFG_DONE, CFG_ERR;
  logic [7:0] HOST_RDATA;

  ulpi_reg_seq #(.MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO), .VERIFY(1)) dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .READY(READY),
    .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL), .REG_DATA_O(REG_DATA_O),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
    .HOST_REQ(HOST_REQ), .HOST_RW(HOST_RW), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
    .HOST_ACK(HOST_ACK), .HOST_RDATA(HOST_RDATA), .HOST_ERR(HOST_ERR),
    .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR)
  );

  initial forever #8 CLK_60M = ~CLK_60M;

  int unsigned cyc = 0;
  always @(posedge CLK_60M) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit rw; bit [5:0] addr; bit [7:0] data; int unsigned gap; } strobe_t;
  typedef struct { bit err; bit [7:0] rdata; } hresp_t;
  strobe_t exp_strobe[$];
  hresp_t  exp_host[$];

  // Link behaviour knobs (read by both the link model and the reference model)
  bit       silent = 0;
  bit       bad_rb04 = 0;
  bit       fail_w04_arm = 0;
  bit [7:0] link_mem[64];
  // Reference model state
  bit       ref_fail_w04 = 0;
  bit [7:0] ref_mem[64];
  bit       exp_cfg_err = 0;

  bit [5:0] tbl_a[3] = '{6'h0A, 6'h04, 6'h07};
  bit [7:0] tbl_d[3] = '{8'h00, 8'h45, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Link outcome of one transaction: 0 = DONE, 1 = FAIL, 2 = no response
  function automatic int model_txn(input bit rw, input bit [5:0] a, input bit [7:0] d,
                                   output bit [7:0] rd);
    rd = 8'h00;
    if (silent) return 2;
    if (rw && a == 6'h04 && ref_fail_w04) begin
      ref_fail_w04 = 0;
      return 1;
    end
    if (rw) ref_mem[a] = d;
    else    rd = (bad_rb04 && a == 6'h04) ? 8'h44 : ref_mem[a];
    return 0;
  endfunction

  task automatic predict_cfg();
    for (int e = 0; e < 3; e++) begin
      bit good;
      bit prev_silent;
      good = 0;
      prev_silent = 0;
      for (int att = 0; att <= int'(MAXR) && !good; att++) begin
        int k;
        bit [7:0] rd;
        exp_strobe.push_back('{1'b1, tbl_a[e], tbl_d[e], (att > 0 && prev_silent) ? TMO + 1 : 0});
        k = model_txn(1'b1, tbl_a[e], tbl_d[e], rd);
        if (k != 0) begin
          prev_silent = (k == 2);
          continue;
        end
        exp_strobe.push_back('{1'b0, tbl_a[e], 8'h00, 0});
        k = model_txn(1'b0, tbl_a[e], 8'h00, rd);
        good = (k == 0 && rd == tbl_d[e]);
        prev_silent = (k == 2);
      end
      if (!good) exp_cfg_err = 1;
    end
  endtask

  task automatic predict_host(input bit rw, input bit [5:0] a, input bit [7:0] d);
    bit prev_silent;
    prev_silent = 0;
    for (int att = 0; att <= int'(MAXR); att++) begin
      int k;
      bit [7:0] rd;
      exp_strobe.push_back('{rw, a, d, (att > 0 && prev_silent) ? TMO + 1 : 0});
      k = model_txn(rw, a, d, rd);
      if (k == 0) begin
        exp_host.push_back('{1'b0, rw ? 8'h00 : rd});
        return;
      end
      prev_silent = (k == 2);
    end
    exp_host.push_back('{1'b1, 8'h00});
  endtask

  // Link model: responds LAT cycles after each strobe unless silent; READY low cancels.
  initial begin : link_model
    int       cd;
    bit       rw_l;
    bit [5:0] a_l;
    bit [7:0] d_l;
    cd = 0;
    forever begin
      @(negedge CLK_60M);
      REG_DONE = 1'b0;
      REG_FAIL = 1'b0;
      if (!NRST_A_USB || !READY) begin
        cd = 0;
      end else if (REG_EN) begin
        rw_l = REG_RW;
        a_l  = REG_ADDR;
        d_l  = REG_DATA_I;
        cd   = silent ? 0 : int'(LAT);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (rw_l && a_l == 6'h04 && fail_w04_arm) begin
            fail_w04_arm = 0;
            REG_FAIL = 1'b1;
          end else begin
            REG_DONE = 1'b1;
            if (rw_l) begin
              link_mem[a_l] = d_l;
              REG_DATA_O = 8'($urandom);
            end else begin
              REG_DATA_O = (bad_rb04 && a_l == 6'h04) ? 8'h44 : link_mem[a_l];
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    bit          prev_en;
    int unsigned last_cyc;
    strobe_t     s;
    hresp_t      h;
    prev_en  = 0;
    last_cyc = 0;
    forever begin
      @(negedge CLK_60M);
      if (REG_EN === 1'b1) begin
        check("reg_en_one_cycle", 32'(prev_en), 32'd0);
        if (exp_strobe.size() == 0) begin
          fail_now("strobe", $sformatf("unexpected REG_EN rw=%0d addr=%0h", REG_RW, REG_ADDR));
        end else begin
          s = exp_strobe.pop_front();
          check("strobe_rw", 32'(REG_RW), 32'(s.rw));
          check("strobe_addr", 32'(REG_ADDR), 32'(s.addr));
          if (s.rw) check("strobe_wdata", 32'(REG_DATA_I), 32'(s.data));
          if (s.gap != 0) check("strobe_gap", cyc - last_cyc, s.gap);
        end
        last_cyc = cyc;
      end
      prev_en = (REG_EN === 1'b1);
      if (HOST_ACK === 1'b1) begin
        if (exp_host.size() == 0) begin
          fail_now("host_ack", "unexpected HOST_ACK");
        end else begin
          h = exp_host.pop_front();
          check("host_err", 32'(HOST_ERR), 32'(h.err));
          if (!h.err) check("host_rdata", 32'(HOST_RDATA), 32'(h.rdata));
        end
      end
    end
  end

  task automatic do_reset();
    NRST_A_USB = 1'b0;
    READY      = 1'b0;
    HOST_REQ   = 1'b0;
    #1;
    check("rst_reg_en", 32'(REG_EN), 32'd0);
    check("rst_reg_rw", 32'(REG_RW), 32'd0);
    check("rst_reg_addr", 32'(REG_ADDR), 32'd0);
    check("rst_reg_data_i", 32'(REG_DATA_I), 32'd0);
    check("rst_host_ack", 32'(HOST_ACK), 32'd0);
    check("rst_host_err", 32'(HOST_ERR), 32'd0);
    check("rst_host_rdata", 32'(HOST_RDATA), 32'd0);
    check("rst_cfg_done", 32'(CFG_DONE), 32'd0);
    check("rst_cfg_err", 32'(CFG_ERR), 32'd0);
    repeat (3) @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
    exp_strobe.delete();
    exp_host.delete();
    exp_cfg_err = 0;
  endtask

  task automatic bring_up(input string tag);
    int n;
    repeat (10) @(negedge CLK_60M);
    READY = 1'b1;
    for (n = 0; n < int'(BUDGET); n++) begin
      @(negedge CLK_60M);
      if (CFG_DONE === 1'b1) break;
    end
    if (n == int'(BUDGET)) fail_now({tag, "_cfg_done"}, "timed out waiting for CFG_DONE");
    check({tag, "_cfg_done"}, 32'(CFG_DONE), 32'd1);
    check({tag, "_cfg_err"}, 32'(CFG_ERR), 32'(exp_cfg_err));
  endtask

  task automatic start_host(input bit rw, input bit [5:0] a, input bit [7:0] d);
    HOST_RW    = rw;
    HOST_ADDR  = a;
    HOST_WDATA = d;
    HOST_REQ   = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    for (n = 0; n < int'(BUDGET); n++) begin
      @(negedge CLK_60M);
      if (HOST_ACK === 1'b1) break;
    end
    if (n == int'(BUDGET)) fail_now({tag, "_ack"}, "timed out waiting for HOST_ACK");
    HOST_REQ = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_strobes_left"}, 32'(exp_strobe.size()), 32'd0);
    check({tag, "_acks_left"}, 32'(exp_host.size()), 32'd0);
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 64; i++) begin
      link_mem[i] = 8'($urandom);
      ref_mem[i]  = link_mem[i];
    end
    #3;
    do_reset();

    // Clean table; a host read raised before READY is held off until RUN.
    predict_cfg();
    predict_host(1'b0, 6'h16, 8'h00);
    start_host(1'b0, 6'h16, 8'h00);
    bring_up("clean");
    wait_ack("clean_host");
    check_drained("clean");

    // First write to 0x04 aborted by the link: reissued once.
    do_reset();
    fail_w04_arm = 1;
    ref_fail_w04 = 1;
    predict_cfg();
    bring_up("fail04");
    check_drained("fail04");

    // Readback of 0x04 always wrong: entry exhausted, 0x07 still written.
    do_reset();
    bad_rb04 = 1;
    predict_cfg();
    bring_up("badrb");
    repeat (5) @(negedge CLK_60M);
    check_drained("badrb");
    bad_rb04 = 0;

    // Silent link: every attempt times out, then a silent host read.
    do_reset();
    silent = 1;
    predict_cfg();
    bring_up("silent");
    predict_host(1'b0, 6'h16, 8'h00);
    start_host(1'b0, 6'h16, 8'h00);
    wait_ack("silent_host");
    repeat (3) @(negedge CLK_60M);
    silent = 0;

    // Responsive host read and a random host write.
    predict_host(1'b0, 6'h16, 8'h00);
    start_host(1'b0, 6'h16, 8'h00);
    wait_ack("host_rd");
    repeat (2) @(negedge CLK_60M);
    begin
      bit [5:0] wa;
      bit [7:0] wd;
      wa = 6'($urandom_range(0, 63));
      wd = 8'($urandom);
      predict_host(1'b1, wa, wd);
      start_host(1'b1, wa, wd);
      wait_ack("host_wr");
    end
    repeat (2) @(negedge CLK_60M);

    // Host write in flight when READY drops: error ACK, table rerun on return.
    exp_strobe.push_back('{1'b1, 6'h16, 8'h3C, 0});
    exp_host.push_back('{1'b1, 8'h00});
    start_host(1'b1, 6'h16, 8'h3C);
    for (n = 0; n < int'(BUDGET); n++) begin
      @(negedge CLK_60M);
      if (REG_EN === 1'b1) break;
    end
    if (n == int'(BUDGET)) fail_now("drop_strobe", "timed out waiting for REG_EN");
    repeat (2) @(negedge CLK_60M);
    READY = 1'b0;
    wait_ack("drop");
    check("drop_cfg_done", 32'(CFG_DONE), 32'd0);
    repeat (5) @(negedge CLK_60M);
    predict_cfg();
    bring_up("rerun");
    repeat (5) @(negedge CLK_60M);
    check_drained("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_seq.md
# ulpi_reg_seq

Register-access sequencer upstream of the ULPI link's register port. Once the link reports READY it writes a fixed PHY configuration table, verifies each write by readback, and retries on PHY abort, timeout or mismatch. After configuration it serves runtime register reads and writes from a host-side request port. It is the only driver of the link's REG_* inputs.

## Interface
Parameters:
- MAX_RETRY, 3: extra attempts per transaction after the first; range 0..7.
- TIMEOUT_CYCLES, 255: cycles to wait for REG_DONE/REG_FAIL before counting a failure; range 1..65535.
- VERIFY, 1: 1 = read back and compare each config write; 0 = skip readback.

Ports:
- CLK_60M  in  1  clock
- NRST_A_USB  in  1  reset, asynchronous, active-low
- READY  in  1  link idle/usable
- REG_DONE  in  1  link transaction done pulse
- REG_FAIL  in  1  link transaction aborted pulse
- REG_DATA_O  in  8  link read data, valid with REG_DONE after a read
- REG_EN  out  1  transaction strobe to link
- REG_RW  out  1  1 = write, 0 = read
- REG_ADDR  out  6  register address
- REG_DATA_I  out  8  write data
- HOST_REQ  in  1  host request, level; held until HOST_ACK
- HOST_RW  in  1  1 = write
- HOST_ADDR  in  6  host address
- HOST_WDATA  in  8  host write data
- HOST_ACK  out  1  one-cycle completion pulse
- HOST_RDATA  out  8  read result, valid with HOST_ACK
- HOST_ERR  out  1  with HOST_ACK: retries exhausted
- CFG_DONE  out  1  configuration table finished
- CFG_ERR  out  1  one or more table entries failed permanently

## Operation
- Config table, in order:
  - 0x0A (OTG Control) = 0x00
  - 0x04 (Function Control) = 0x45 (FS transceiver, TermSelect = 1, OpMode normal, SuspendM = 1)
  - 0x07 (Interface Control) = 0x00
- States:
  - WAIT_READY: enters CFG_ISSUE when READY = 1; entry index 0.
  - CFG_ISSUE: issues a write.
  - CFG_WAIT: on DONE goes to CFG_VRFY_ISSUE if VERIFY = 1, else CFG_NEXT; on FAIL or timeout goes to the retry path.
  - CFG_VRFY_ISSUE: issues a read.
  - CFG_VRFY_WAIT: DONE with REG_DATA_O equal to the written value goes to CFG_NEXT; a mismatch, FAIL or timeout goes to retry, which reissues the write.
  - CFG_NEXT: increments the index; after entry 2 goes to RUN and sets CFG_DONE.
  - RUN: if READY = 1 and HOST_REQ = 1, latches the host fields and goes to HOST_ISSUE.
  - HOST_ISSUE, then HOST_WAIT: DONE pulses HOST_ACK with HOST_RDATA = REG_DATA_O on reads and 0 on writes; FAIL or timeout goes to retry.
- Retry: per-transaction counter, cleared at each new table entry or host request.
  - If the counter is below MAX_RETRY: increment it and return to the issue state.
  - Config entry exhausted: set CFG_ERR (sticky until reset) and skip to CFG_NEXT.
  - Host transaction exhausted: HOST_ACK = 1 with HOST_ERR = 1, then RUN.
- Issue states wait for READY = 1 before strobing.
- REG_DONE/REG_FAIL are ignored outside WAIT states (for example, the link's own init write).
- READY falling in any state other than WAIT_READY:
  - clears CFG_DONE and returns to WAIT_READY;
  - an in-flight host transaction is answered with HOST_ACK = 1, HOST_ERR = 1 in the same cycle;
  - the full table reruns when READY returns.
- HOST_REQ during configuration is held off, with no ACK until RUN.

## Timing
- Reset values:
  - REG_EN, REG_RW, HOST_ACK, HOST_ERR, CFG_DONE, CFG_ERR = 0
  - REG_ADDR = 0, REG_DATA_I = 0, HOST_RDATA = 0
  - state = WAIT_READY
- All outputs are registered.
- REG_EN is exactly one cycle high, in the cycle after the issue state is entered.
- REG_ADDR, REG_RW and REG_DATA_I are valid in that same cycle and held until the next issue.
- The timeout counter starts the cycle after REG_EN. A failure is declared when the count reaches TIMEOUT_CYCLES with no DONE/FAIL.
- DONE and timeout in the same cycle: DONE wins.
- DONE and FAIL in the same cycle: FAIL wins.
- HOST_ACK occurs 1 cycle after the accepting DONE.
- The host must deassert HOST_REQ or present a new request the cycle after ACK. A request still high is taken as a new transaction.
- Asynchronous reset mid-transaction: REG_EN drops immediately and nothing is resumed.

## Structure
- Shared package ulpi_pkg:
  - PHY register address constants (FUNC_CTRL 0x04, IFC_CTRL 0x07, OTG_CTRL 0x0A);
  - config table as a constant array of {addr, data};
  - state encoding constants.
- Sub-module ulpi_reg_txn: a single-transaction engine (strobe, timeout counter, DONE/FAIL capture, readback compare) reused by the config and host paths. The top level holds the sequencing FSM, retry counter and host latch.

## Test plan
- Link model acks every transaction after 5 cycles; READY rises at cycle 10 → writes 0x0A/0x00, 0x04/0x45, 0x07/0x00, each followed by a read of the same address; CFG_DONE = 1, CFG_ERR = 0.
- Model pulses REG_FAIL on the first write to 0x04 → the write is reissued once; the sequence completes with CFG_ERR = 0.
- Model returns 0x44 on every readback of 0x04, MAX_RETRY = 3 → 4 write+read pairs to 0x04, then CFG_ERR = 1, CFG_DONE = 1, entry 0x07 still written.
- Model never responds, TIMEOUT_CYCLES = 20 → REG_EN reissued every 21 cycles.
  - Host read of 0x16 in RUN with the model responding: HOST_ACK = 1, HOST_RDATA = the model value, HOST_ERR = 0.
  - Same read with the model silent: HOST_ERR = 1 after 4 attempts.
- Host write 0x3C to 0x16 in flight, READY drops → HOST_ACK = 1 with HOST_ERR = 1, CFG_DONE = 0; when READY returns the full table is rewritten.
